// File: rtl/lfsr16_pkg.sv
// Shared definitions for the 16-bit LFSR pattern path (generator and checker).
// Polynomial x^16+x^14+x^13+x^11+1, Fibonacci form; the all-zero word is illegal.
package lfsr16_pkg;

    localparam logic [15:0] LFSR_TAPS       = 16'hB400;
    localparam int unsigned DEF_LOCK_CNT    = 4;
    localparam int unsigned DEF_LOSS_THRESH = 8;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } chk_state_e;

    // Taps select q[15], q[13], q[12], q[10]; feedback enters at bit 0.
    function automatic logic [15:0] lfsr16_next(input logic [15:0] q);
        return {q[14:0], ^(q & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/lfsr16_step.sv
// Combinational one-step advance of the 16-bit LFSR.
module lfsr16_step
    import lfsr16_pkg::*;
(
    input  logic [15:0] cur,
    output logic [15:0] nxt
);

    assign nxt = lfsr16_next(cur);

endmodule

// File: rtl/lfsr_16b_checker.sv
// Receive-side LFSR checker: seeds from incoming data, verifies, then free-runs its
// prediction while locked and reports mismatches through pulse, counters and fail flag.
module lfsr_16b_checker
    import lfsr16_pkg::*;
#(
    parameter int unsigned LOCK_CNT    = DEF_LOCK_CNT,
    parameter int unsigned LOSS_THRESH = DEF_LOSS_THRESH,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    input  logic [15:0]      in_data,
    input  logic             clr,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] word_cnt,
    output logic             fail
);

    localparam logic [3:0] LockCntW    = 4'(LOCK_CNT);
    localparam logic [7:0] LossThreshW = 8'(LOSS_THRESH);

    chk_state_e       state_q, state_d;
    logic [15:0]      exp_q, exp_d;
    logic [3:0]       match_q, match_d;
    logic [7:0]       miss_q, miss_d;
    logic             locked_q, locked_d;
    logic             err_pulse_q, err_pulse_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic             fail_q, fail_d;

    logic [15:0] seed_next;
    logic [15:0] run_next;
    logic [3:0]  match_inc;
    logic [7:0]  miss_inc;

    // Seed path follows the received word; run path follows our own prediction.
    lfsr16_step u_step_seed (
        .cur (in_data),
        .nxt (seed_next)
    );

    lfsr16_step u_step_run (
        .cur (exp_q),
        .nxt (run_next)
    );

    assign match_inc = match_q + 4'd1;
    assign miss_inc  = miss_q + 8'd1;

    always_comb begin
        state_d     = state_q;
        exp_d       = exp_q;
        match_d     = match_q;
        miss_d      = miss_q;
        err_pulse_d = 1'b0;
        err_cnt_d   = err_cnt_q;
        word_cnt_d  = word_cnt_q;
        fail_d      = fail_q;

        if (in_valid) begin
            unique case (state_q)
                LOCKED: begin
                    // Never reseed while locked so one corrupted word costs one error.
                    exp_d = run_next;
                    if (word_cnt_q != '1) begin
                        word_cnt_d = word_cnt_q + CNT_W'(1);
                    end
                    if (in_data != exp_q) begin
                        err_pulse_d = 1'b1;
                        fail_d      = 1'b1;
                        if (err_cnt_q != '1) begin
                            err_cnt_d = err_cnt_q + CNT_W'(1);
                        end
                        if (miss_inc == LossThreshW) begin
                            state_d = HUNT;
                            match_d = '0;
                            miss_d  = '0;
                        end else begin
                            miss_d = miss_inc;
                        end
                    end else begin
                        miss_d = '0;
                    end
                end
                HUNT, VERIFY: begin
                    if (state_q == VERIFY && in_data == exp_q) begin
                        exp_d = seed_next;
                        if (match_inc == LockCntW) begin
                            state_d = LOCKED;
                            match_d = '0;
                        end else begin
                            match_d = match_inc;
                        end
                    end else if (in_data != '0) begin
                        exp_d   = seed_next;
                        match_d = '0;
                        state_d = VERIFY;
                    end else begin
                        state_d = HUNT;
                        match_d = '0;
                    end
                end
                default: begin
                    state_d = HUNT;
                    match_d = '0;
                    miss_d  = '0;
                end
            endcase
        end

        // Clear beats a same-cycle error for the counters and fail; the pulse is kept.
        if (clr) begin
            err_cnt_d  = '0;
            word_cnt_d = '0;
            fail_d     = 1'b0;
        end
    end

    assign locked_d = (state_d == LOCKED);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= HUNT;
            exp_q       <= '0;
            match_q     <= '0;
            miss_q      <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
            word_cnt_q  <= '0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            exp_q       <= exp_d;
            match_q     <= match_d;
            miss_q      <= miss_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
            word_cnt_q  <= word_cnt_d;
            fail_q      <= fail_d;
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign err_cnt   = err_cnt_q;
    assign word_cnt  = word_cnt_q;
    assign fail      = fail_q;

endmodule

// File: tb/tb_lfsr_16b_checker.sv
// Scoreboard bench for lfsr_16b_checker: a 16-bit and a 4-bit-counter instance share
// stimulus; a behavioural model queues expected outputs, a monitor pops and compares.
module tb_lfsr_16b_checker;

    localparam int LOCK = 4;
    localparam int LOSS = 8;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = 16'h0000;
    logic        clr = 1'b0;

    logic        d_locked, d_pulse, d_fail;
    logic [15:0] d_err, d_word;
    logic        s_locked, s_pulse, s_fail;
    logic [3:0]  s_err, s_word;

    always #5 clk = ~clk;

    lfsr_16b_checker #(.LOCK_CNT(LOCK), .LOSS_THRESH(LOSS), .CNT_W(16)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_data(in_data), .clr(clr),
        .locked(d_locked), .err_pulse(d_pulse), .err_cnt(d_err), .word_cnt(d_word),
        .fail(d_fail)
    );

    lfsr_16b_checker #(.LOCK_CNT(LOCK), .LOSS_THRESH(LOSS), .CNT_W(4)) dut4 (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_data(in_data), .clr(clr),
        .locked(s_locked), .err_pulse(s_pulse), .err_cnt(s_err), .word_cnt(s_word),
        .fail(s_fail)
    );

    typedef struct packed {
        logic        locked;
        logic        pulse;
        logic        fail;
        logic [15:0] err;
        logic [15:0] word;
        logic [3:0]  err4;
        logic [3:0]  word4;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: mode 0=searching, 1=confirming, 2=locked; counts are unbounded.
    int          m_mode = 0;
    logic [15:0] m_pred = 16'h0000;
    int          m_good = 0;
    int          m_bad = 0;
    longint      m_err = 0;
    longint      m_word = 0;
    logic        m_fail = 1'b0;
    logic        m_pulse = 1'b0;
    logic [15:0] seq;

    function automatic logic [15:0] ref_next(input logic [15:0] q);
        logic fb;
        fb = q[15] ^ q[13] ^ q[12] ^ q[10];
        return {q[14:0], fb};
    endfunction

    function automatic logic [15:0] clamp16(input longint v);
        return (v > 65535) ? 16'hFFFF : 16'(v);
    endfunction

    function automatic logic [3:0] clamp4(input longint v);
        return (v > 15) ? 4'hF : 4'(v);
    endfunction

    task automatic cmp(input string nm, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic v, input logic [15:0] d,
                              input logic c);
        m_pulse = 1'b0;
        if (!r) begin
            m_mode = 0; m_pred = 16'h0000; m_good = 0; m_bad = 0;
            m_err = 0; m_word = 0; m_fail = 1'b0;
            return;
        end
        if (v) begin
            if (m_mode == 2) begin
                m_word++;
                if (d != m_pred) begin
                    m_pulse = 1'b1; m_err++; m_fail = 1'b1; m_bad++;
                end else begin
                    m_bad = 0;
                end
                m_pred = ref_next(m_pred);
                if (m_bad == LOSS) begin
                    m_mode = 0; m_good = 0; m_bad = 0;
                end
            end else if (m_mode == 1 && d == m_pred) begin
                m_good++;
                m_pred = ref_next(d);
                if (m_good == LOCK) m_mode = 2;
            end else if (d != 16'h0000) begin
                m_pred = ref_next(d); m_good = 0; m_mode = 1;
            end else begin
                m_mode = 0;
            end
        end
        if (c) begin
            m_err = 0; m_word = 0; m_fail = 1'b0;
        end
    endtask

    // One clock of stimulus: drive on the falling edge, queue what must appear next.
    task automatic cyc(input logic r, input logic v, input logic [15:0] d, input logic c);
        exp_t e;
        @(negedge clk);
        rstn = r; in_valid = v; in_data = d; clr = c;
        model_step(r, v, d, c);
        e.locked = (m_mode == 2);
        e.pulse  = m_pulse;
        e.fail   = m_fail;
        e.err    = clamp16(m_err);
        e.word   = clamp16(m_word);
        e.err4   = clamp4(m_err);
        e.word4  = clamp4(m_word);
        sb.push_back(e);
    endtask

    task automatic feed(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(1'b1, 1'b1, seq, 1'b0);
            seq = ref_next(seq);
        end
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                cmp("locked",    16'(d_locked), 16'(e.locked));
                cmp("err_pulse", 16'(d_pulse),  16'(e.pulse));
                cmp("fail",      16'(d_fail),   16'(e.fail));
                cmp("err_cnt",   d_err,         e.err);
                cmp("word_cnt",  d_word,        e.word);
                cmp("locked4",   16'(s_locked), 16'(e.locked));
                cmp("err_cnt4",  16'(s_err),    16'(e.err4));
                cmp("word_cnt4", 16'(s_word),   16'(e.word4));
                cmp("fail4",     16'(s_fail),   16'(e.fail));
            end
        end
    end

    initial begin : stim
        int kind;
        logic [15:0] w;

        // Lock from seed ACE1: four words are not enough, the fifth locks.
        cyc(1'b0, 1'b0, 16'h0000, 1'b0);
        settle();
        cmp("t0_reset_locked", 16'(d_locked), 16'd0);
        cmp("t0_reset_err", d_err, 16'd0);
        seq = 16'hACE1;
        feed(4);
        settle();
        cmp("t1_prelock", 16'(d_locked), 16'd0);
        feed(1);
        settle();
        cmp("t1_locked", 16'(d_locked), 16'd1);
        cmp("t1_fail", 16'(d_fail), 16'd0);

        // Single bit-0 flip while locked.
        feed(3);
        cyc(1'b1, 1'b1, seq ^ 16'h0001, 1'b0);
        seq = ref_next(seq);
        settle();
        cmp("t2_pulse", 16'(d_pulse), 16'd1);
        feed(3);
        settle();
        cmp("t2_err_cnt", d_err, 16'd1);
        cmp("t2_fail", 16'(d_fail), 16'd1);
        cmp("t2_locked", 16'(d_locked), 16'd1);
        cmp("t2_pulse_gone", 16'(d_pulse), 16'd0);

        // Loss of lock after eight consecutive misses, then relock.
        cyc(1'b0, 1'b0, 16'h0000, 1'b0);
        seq = 16'hACE1;
        feed(5);
        for (int i = 0; i < 7; i++) cyc(1'b1, 1'b1, 16'h1234, 1'b0);
        settle();
        cmp("t3_still_locked", 16'(d_locked), 16'd1);
        cyc(1'b1, 1'b1, 16'h1234, 1'b0);
        settle();
        cmp("t3_lost", 16'(d_locked), 16'd0);
        cmp("t3_err8", d_err, 16'd8);
        feed(5);
        settle();
        cmp("t3_relocked", 16'(d_locked), 16'd1);
        cmp("t3_err_hold", d_err, 16'd8);

        // Zero words keep the checker hunting; gaps do not disturb locking.
        cyc(1'b0, 1'b0, 16'h0000, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 16'h0000, 1'b0);
        settle();
        cmp("t4_zero_hunt", 16'(d_locked), 16'd0);
        seq = 16'h59C3;
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b1, seq, 1'b0);
            seq = ref_next(seq);
            cyc(1'b1, 1'b0, 16'(i * 16'h1111), 1'b0);
        end
        settle();
        cmp("t4_gap_locked", 16'(d_locked), 16'd1);

        // clr on an error cycle, then reset while locked.
        cyc(1'b1, 1'b1, seq ^ 16'h0100, 1'b0);
        seq = ref_next(seq);
        cyc(1'b1, 1'b1, seq ^ 16'h0001, 1'b1);
        seq = ref_next(seq);
        settle();
        cmp("t5_clr_err", d_err, 16'd0);
        cmp("t5_clr_fail", 16'(d_fail), 16'd0);
        cmp("t5_clr_pulse", 16'(d_pulse), 16'd1);
        cyc(1'b0, 1'b1, seq, 1'b1);
        seq = ref_next(seq);
        settle();
        cmp("t5_rst_locked", 16'(d_locked), 16'd0);
        cmp("t5_rst_word", d_word, 16'd0);
        cmp("t5_rst_pulse", 16'(d_pulse), 16'd0);
        feed(4);
        settle();
        cmp("t5_relock_early", 16'(d_locked), 16'd0);
        feed(1);
        settle();
        cmp("t5_relock", 16'(d_locked), 16'd1);

        // Twenty errors, spaced so lock holds; the 4-bit counters must stick at F.
        cyc(1'b0, 1'b0, 16'h0000, 1'b0);
        feed(5);
        for (int i = 0; i < 25; i++) begin
            cyc(1'b1, 1'b1, (i % 5 == 4) ? seq : (seq ^ 16'h8000), 1'b0);
            seq = ref_next(seq);
        end
        settle();
        cmp("t6_err_sat4", 16'(s_err), 16'h000F);
        cmp("t6_err_16", d_err, 16'd20);
        cmp("t6_locked", 16'(d_locked), 16'd1);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            kind = int'($urandom_range(0, 99));
            if (kind < 70)      w = seq;
            else if (kind < 85) w = seq ^ (16'h0001 << $urandom_range(0, 15));
            else if (kind < 92) w = 16'h0000;
            else                w = 16'($urandom);
            if ($urandom_range(0, 299) == 0) seq = 16'($urandom_range(1, 65535));
            cyc(($urandom_range(0, 199) != 0), ($urandom_range(0, 3) != 0), w,
                ($urandom_range(0, 49) == 0));
            if (in_valid && kind < 85) seq = ref_next(seq);
        end

        cyc(1'b1, 1'b0, 16'h0000, 1'b0);
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        #3;
        cmp("sb_drain", 16'(sb.size()), 16'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
